// File: rtl/cpu_pkg.sv
// Shared sequencer types and constants: PC width, jump nibble width, return-stack size, reset PC.
// Also holds the pm_addr source selector and the jump-target helper.
package cpu_pkg;

    localparam int PC_WIDTH         = 8;
    localparam int JMP_NIBBLE_WIDTH = 4;
    localparam int STACK_DEPTH      = 4;
    localparam int DEPTH_WIDTH      = $clog2(STACK_DEPTH + 1);
    localparam int PTR_WIDTH        = $clog2(STACK_DEPTH);

    typedef logic [PC_WIDTH-1:0] pc_t;

    localparam pc_t RESET_PC = 8'h00;

    typedef enum logic [2:0] {
        SRC_RESET,
        SRC_RET,
        SRC_CALL,
        SRC_JMP,
        SRC_JNZ,
        SRC_INC
    } pm_src_e;

    // Jump targets land on 16-byte boundaries: the nibble becomes the upper bits.
    function automatic pc_t jump_target(input logic [JMP_NIBBLE_WIDTH-1:0] nib);
        return {nib, {(PC_WIDTH - JMP_NIBBLE_WIDTH){1'b0}}};
    endfunction

endpackage

// File: rtl/program_sequencer_if.sv
// Decoder <-> program sequencer bundle: jump/call/return requests in, PC and stack status out.
interface program_sequencer_if;
    import cpu_pkg::*;

    logic                        jmp;
    logic                        jmp_nz;
    logic [JMP_NIBBLE_WIDTH-1:0] jmp_addr;
    logic                        dont_jmp;
    logic                        call;
    logic                        ret;
    pc_t                         pm_addr;
    pc_t                         pc;
    logic                        sync_reset;
    logic [DEPTH_WIDTH-1:0]      stack_depth;
    logic                        stack_err;
    pc_t                         from_PS;

    modport master (
        output jmp, jmp_nz, jmp_addr, dont_jmp, call, ret,
        input  pm_addr, pc, sync_reset, stack_depth, stack_err, from_PS
    );

    modport slave (
        input  jmp, jmp_nz, jmp_addr, dont_jmp, call, ret,
        output pm_addr, pc, sync_reset, stack_depth, stack_err, from_PS
    );

endinterface

// File: rtl/return_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry, and a pop
// when empty sets a sticky error. The top entry is read combinationally so a return has zero latency.
module return_stack
    import cpu_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  pc_t                    push_data,
    output pc_t                    top_data,
    output logic                   nonempty,
    output logic [DEPTH_WIDTH-1:0] depth,
    output logic                   err
);

    localparam logic [PTR_WIDTH-1:0]   PTR_ONE    = PTR_WIDTH'(1);
    localparam logic [DEPTH_WIDTH-1:0] DEPTH_ONE  = DEPTH_WIDTH'(1);
    localparam logic [DEPTH_WIDTH-1:0] DEPTH_FULL = DEPTH_WIDTH'(STACK_DEPTH);

    pc_t                    mem_q [STACK_DEPTH];
    logic [PTR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_WIDTH-1:0] depth_q, depth_d;
    logic                   err_q, err_d;

    genvar gi;
    generate
        for (gi = 0; gi < STACK_DEPTH; gi++) begin : g_entry
            pc_t entry_q, entry_d;

            assign entry_d    = (push && !pop && wr_ptr_q == PTR_WIDTH'(gi)) ? push_data : entry_q;
            assign mem_q[gi]  = entry_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) entry_q <= RESET_PC;
                else          entry_q <= entry_d;
            end
        end
    endgenerate

    // wr_ptr is the next free slot; when full it also points at the oldest entry.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        depth_d  = depth_q;
        err_d    = err_q;
        if (pop) begin
            if (depth_q != '0) begin
                wr_ptr_d = wr_ptr_q - PTR_ONE;
                depth_d  = depth_q - DEPTH_ONE;
            end else begin
                err_d = 1'b1;
            end
        end else if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (depth_q != DEPTH_FULL) depth_d = depth_q + DEPTH_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            depth_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            depth_q  <= depth_d;
            err_q    <= err_d;
        end
    end

    assign top_data = mem_q[wr_ptr_q - PTR_ONE];
    assign nonempty = (depth_q != '0);
    assign depth    = depth_q;
    assign err      = err_q;

endmodule

// File: rtl/program_sequencer.sv
// Program sequencer: selects the next program-memory address (reset/ret/call/jmp/jmp_nz/pc+1).
// Define CALL_STACK_EN to build the call/return stack; otherwise call and ret are ignored.
module program_sequencer
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    program_sequencer_if.slave bus
);

    logic                   sync_meta_q, sync_meta_d;
    logic                   sync_reset_q, sync_reset_d;
    pc_t                    pc_q, pc_d;
    pc_t                    pc_inc;
    pc_t                    pm_addr;
    pm_src_e                pm_src;
    logic                   call_req, ret_req;
    logic                   stack_push, stack_pop, stack_nonempty;
    pc_t                    stack_top;
    logic [DEPTH_WIDTH-1:0] stack_depth;
    logic                   stack_err;

    assign pc_inc = pc_q + PC_WIDTH'(1);

    // A simultaneous call and ret resolves to ret alone, and nothing moves while in reset.
    assign stack_pop  = ret_req & ~sync_reset_q;
    assign stack_push = call_req & ~ret_req & ~sync_reset_q;

`ifdef CALL_STACK_EN
    assign call_req = bus.call;
    assign ret_req  = bus.ret;

    return_stack u_return_stack (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (stack_push),
        .pop       (stack_pop),
        .push_data (pc_inc),
        .top_data  (stack_top),
        .nonempty  (stack_nonempty),
        .depth     (stack_depth),
        .err       (stack_err)
    );
`else
    logic unused_stack_reqs;
    assign unused_stack_reqs = bus.call ^ bus.ret ^ stack_push ^ stack_pop;
    assign call_req       = 1'b0;
    assign ret_req        = 1'b0;
    assign stack_top      = RESET_PC;
    assign stack_nonempty = 1'b0;
    assign stack_depth    = '0;
    assign stack_err      = 1'b0;
`endif

    always_comb begin
        pm_src = SRC_INC;
        if (sync_reset_q)                      pm_src = SRC_RESET;
        else if (ret_req)                      pm_src = stack_nonempty ? SRC_RET : SRC_INC;
        else if (call_req)                     pm_src = SRC_CALL;
        else if (bus.jmp)                      pm_src = SRC_JMP;
        else if (bus.jmp_nz && !bus.dont_jmp)  pm_src = SRC_JNZ;

        pm_addr = pc_inc;
        case (pm_src)
            SRC_RESET:                 pm_addr = RESET_PC;
            SRC_RET:                   pm_addr = stack_top;
            SRC_CALL, SRC_JMP, SRC_JNZ: pm_addr = jump_target(bus.jmp_addr);
            default:                   pm_addr = pc_inc;
        endcase

        pc_d         = pm_addr;
        sync_meta_d  = 1'b0;
        sync_reset_d = sync_meta_q;
    end

    // Both synchroniser flops set asynchronously, so sync_reset clears on the 2nd edge after release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta_q  <= 1'b1;
            sync_reset_q <= 1'b1;
            pc_q         <= RESET_PC;
        end else begin
            sync_meta_q  <= sync_meta_d;
            sync_reset_q <= sync_reset_d;
            pc_q         <= pc_d;
        end
    end

    assign bus.pm_addr     = pm_addr;
    assign bus.pc          = pc_q;
    assign bus.from_PS     = pc_q;
    assign bus.sync_reset  = sync_reset_q;
    assign bus.stack_depth = stack_depth;
    assign bus.stack_err   = stack_err;

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: jump table, reset/stack corner sequences and random stimulus
// checked against a queue-based reference model (stack checks only when CALL_STACK_EN is defined).
module tb_program_sequencer;

`ifdef CALL_STACK_EN
    localparam bit STK_EN = 1'b1;
`else
    localparam bit STK_EN = 1'b0;
`endif

    logic clk;
    logic reset_n;

    program_sequencer_if bus ();

    program_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    // Reference model state
    int m_pc;
    int m_stk[$];
    bit m_err;
    bit m_sync;
    int m_rel_edges;

    typedef struct {
        logic [3:0] start_nib;
        int         incs;
        bit         j;
        bit         jnz;
        logic [3:0] a;
        bit         dz;
        int         exp_pm;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int model_pm(bit j, bit jnz, logic [3:0] a, bit dz, bit c, bit r);
        int inc;
        int tgt;
        inc = (m_pc + 1) % 256;
        tgt = int'(a) * 16;
        if (m_sync) return 0;
        if (STK_EN && r) return (m_stk.size() > 0) ? m_stk[$] : inc;
        if ((STK_EN && c) || j || (jnz && !dz)) return tgt;
        return inc;
    endfunction

    // Called at posedge+1: drive inputs, check mid-cycle, advance one clock.
    task automatic do_cycle(input bit j, input bit jnz, input logic [3:0] a, input bit dz,
                            input bit c, input bit r, input int want_pm);
        int exp_pm;
        bus.jmp      = j;
        bus.jmp_nz   = jnz;
        bus.jmp_addr = a;
        bus.dont_jmp = dz;
        bus.call     = c;
        bus.ret      = r;
        #3;
        exp_pm = model_pm(j, jnz, a, dz, c, r);
        chk("pm_addr", int'(bus.pm_addr), exp_pm);
        chk("pc", int'(bus.pc), m_pc);
        chk("from_PS", int'(bus.from_PS), m_pc);
        chk("sync_reset", int'(bus.sync_reset), int'(m_sync));
        chk("stack_depth", int'(bus.stack_depth), m_stk.size());
        chk("stack_err", int'(bus.stack_err), int'(m_err));
        if (want_pm >= 0) chk("pm_expected", int'(bus.pm_addr), want_pm);
        $display("[TB] cyc %0d j=%0b jnz=%0b a=%h dz=%0b call=%0b ret=%0b pc=%02h pm=%02h depth=%0d err=%0b",
                 cyc, j, jnz, a, dz, c, r, bus.pc, bus.pm_addr, bus.stack_depth, bus.stack_err);
        @(posedge clk);
        cyc++;
        if (!m_sync && STK_EN) begin
            if (r) begin
                if (m_stk.size() > 0) void'(m_stk.pop_back());
                else m_err = 1'b1;
            end else if (c) begin
                m_stk.push_back((m_pc + 1) % 256);
                if (m_stk.size() > 4) void'(m_stk.pop_front());
            end
        end
        m_pc = exp_pm;
        if (m_sync) begin
            m_rel_edges++;
            if (m_rel_edges >= 2) m_sync = 1'b0;
        end
        #1;
    endtask

    task automatic idle(input int want_pm);
        do_cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, want_pm);
    endtask

    // Asserts reset_n at posedge+1 (mid-operation), holds it with random requests, then releases.
    task automatic do_reset(input int cycles);
        reset_n = 1'b0;
        m_pc = 0;
        m_stk.delete();
        m_err = 1'b0;
        m_sync = 1'b1;
        m_rel_edges = 0;
        for (int k = 0; k < cycles; k++) begin
            bus.jmp      = 1'($urandom_range(0, 1));
            bus.jmp_nz   = 1'($urandom_range(0, 1));
            bus.jmp_addr = 4'($urandom_range(0, 15));
            bus.dont_jmp = 1'($urandom_range(0, 1));
            bus.call     = 1'($urandom_range(0, 1));
            bus.ret      = 1'($urandom_range(0, 1));
            #3;
            chk("rst_pc", int'(bus.pc), 0);
            chk("rst_pm_addr", int'(bus.pm_addr), 0);
            chk("rst_sync_reset", int'(bus.sync_reset), 1);
            chk("rst_depth", int'(bus.stack_depth), 0);
            chk("rst_err", int'(bus.stack_err), 0);
            chk("rst_from_PS", int'(bus.from_PS), 0);
            $display("[TB] cyc %0d reset_n=0 pc=%02h pm=%02h sync=%0b", cyc, bus.pc, bus.pm_addr, bus.sync_reset);
            @(posedge clk);
            cyc++;
            #1;
        end
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n      = 1'b0;
        bus.jmp      = 1'b0;
        bus.jmp_nz   = 1'b0;
        bus.jmp_addr = 4'h0;
        bus.dont_jmp = 1'b0;
        bus.call     = 1'b0;
        bus.ret      = 1'b0;

        tbl[0] = '{4'h3, 10, 1'b1, 1'b0, 4'h7, 1'b0, 8'h70};
        tbl[1] = '{4'h1, 0,  1'b0, 1'b1, 4'h2, 1'b1, 8'h11};
        tbl[2] = '{4'h1, 0,  1'b0, 1'b1, 4'h2, 1'b0, 8'h20};
        tbl[3] = '{4'hF, 15, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00};
        tbl[4] = '{4'h2, 3,  1'b1, 1'b1, 4'hC, 1'b1, 8'hC0};
        tbl[5] = '{4'h8, 1,  1'b0, 1'b1, 4'h0, 1'b0, 8'h00};
        tbl[6] = '{4'h4, 2,  1'b0, 1'b0, 4'h9, 1'b1, 8'h43};

        @(posedge clk);
        #1;

        // Power-up reset, synchroniser release and first increments
        do_reset(3);
        idle(8'h00);
        idle(8'h00);
        idle(8'h01);
        idle(8'h02);

        // Jump table
        for (int i = 0; i < 7; i++) begin
            do_cycle(1'b1, 1'b0, tbl[i].start_nib, 1'b0, 1'b0, 1'b0, int'(tbl[i].start_nib) * 16);
            for (int k = 0; k < tbl[i].incs; k++) idle(-1);
            do_cycle(tbl[i].j, tbl[i].jnz, tbl[i].a, tbl[i].dz, 1'b0, 1'b0, tbl[i].exp_pm);
            chk("tbl_pc_next", int'(bus.pc), tbl[i].exp_pm);
        end

`ifdef CALL_STACK_EN
        // Five nested calls overflow the 4-deep stack, then five returns
        do_reset(3);
        idle(-1);
        idle(-1);
        for (int k = 0; k < 5; k++) begin
            for (int n = 0; n < 5; n++) idle(-1);
            do_cycle(1'b0, 1'b0, 4'(k + 1), 1'b0, 1'b1, 1'b0, (k + 1) * 16);
        end
        chk("full_depth", int'(bus.stack_depth), 4);
        do_cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 8'h46);
        do_cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 8'h36);
        do_cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 8'h26);
        do_cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 8'h16);
        do_cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 8'h17);
        chk("underflow_err", int'(bus.stack_err), 1);
        chk("underflow_depth", int'(bus.stack_depth), 0);

        // call and ret together at depth 1 behave as ret only
        do_reset(1);
        idle(-1);
        idle(-1);
        do_cycle(1'b0, 1'b0, 4'h3, 1'b0, 1'b1, 1'b0, 8'h30);
        do_cycle(1'b0, 1'b0, 4'h9, 1'b0, 1'b1, 1'b1, 8'h01);
        chk("callret_depth", int'(bus.stack_depth), 0);
        do_cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 8'h02);
        chk("callret_no_push_err", int'(bus.stack_err), 1);
`else
        // Without the stack, call and ret are ignored
        do_reset(1);
        idle(-1);
        idle(-1);
        do_cycle(1'b0, 1'b0, 4'h9, 1'b0, 1'b1, 1'b0, 8'h01);
        do_cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 8'h02);
        chk("nostack_err", int'(bus.stack_err), 0);
        chk("nostack_depth", int'(bus.stack_depth), 0);
`endif

        // Random stimulus with occasional mid-operation resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                do_reset(int'($urandom_range(1, 3)));
            end else begin
                do_cycle(($urandom_range(0, 7) == 0),
                         ($urandom_range(0, 3) == 0),
                         4'($urandom_range(0, 15)),
                         1'($urandom_range(0, 1)),
                         ($urandom_range(0, 5) == 0),
                         ($urandom_range(0, 6) == 0),
                         -1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
